// File: rtl/sd_cmd_serial_host.sv
// Serial CMD-line engine for the SD host: frames 40-bit commands with CRC7,
// then captures and CRC-checks the card response and reports it to the master.
module sd_cmd_serial_host #(
  parameter int INIT_CYCLES = 80,
  parameter int RSP_TIMEOUT = 64
) (
  input  logic        CLK_PAD_IO,
  input  logic        RST_PAD_I,
  input  logic        go_idle_i,
  input  logic [15:0] settings_i,
  input  logic [39:0] cmd_i,
  input  logic        req_i,
  output logic        ack_o,
  output logic [39:0] cmd_o,
  output logic [7:0]  status_o,
  output logic        req_o,
  input  logic        ack_i,
  input  logic        cmd_dat_i,
  output logic        cmd_out_o,
  output logic        cmd_oe_o
);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_DLY    = 3'd3,
    ST_WAIT   = 3'd4,
    ST_READ   = 3'd5,
    ST_REPORT = 3'd6
  } state_t;

  localparam logic [7:0] INIT_LAST  = 8'(INIT_CYCLES);
  localparam logic [7:0] TMO_LAST   = 8'(RSP_TIMEOUT - 1);
  localparam logic [7:0] WRITE_LAST = 8'd47;
  localparam logic [7:0] SHORT_LAST = 8'd47;
  localparam logic [7:0] LONG_LAST  = 8'd135;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic d);
    logic fb;
    fb = crc[6] ^ d;
    crc7_step = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] data);
    logic [6:0] c;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      c = crc7_step(c, data[i]);
    end
    crc7_40 = c;
  endfunction

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [47:0] r_tx;
  logic [2:0]  r_dly;
  logic        r_rsp_none;
  logic        r_rsp_long;
  logic [6:0]  r_crc;
  logic [6:0]  r_rx_crc;
  logic        r_dat_ava;
  logic        r_crc_valid;
  logic        r_timeout;
  logic        r_init_done;
  logic        r_ack;
  logic        r_req;
  logic [39:0] r_cmd;
  logic        r_cmd_out;
  logic        r_oe;
  logic        r_req_meta;
  logic        r_req_s;
  logic        r_req_d;
  logic        r_ack_meta;
  logic        r_ack_s;
  logic        w_req_rise;
  logic        w_unused_settings;

  assign w_req_rise        = r_req_s & ~r_req_d;
  assign w_unused_settings = ^{settings_i[15:11], settings_i[7]};

  assign ack_o     = r_ack;
  assign req_o     = r_req;
  assign cmd_o     = r_cmd;
  assign cmd_out_o = r_cmd_out;
  assign cmd_oe_o  = r_oe;
  assign status_o  = {1'b0, r_dat_ava, r_crc_valid, r_timeout, 3'b000, r_init_done};

  // Synchronise the master handshake lines; r_req_d gives req edge history.
  always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
    if (RST_PAD_I) begin
      r_req_meta <= 1'b0;
      r_req_s    <= 1'b0;
      r_req_d    <= 1'b0;
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
    end else begin
      r_req_meta <= req_i;
      r_req_s    <= r_req_meta;
      r_req_d    <= r_req_s;
      r_ack_meta <= ack_i;
      r_ack_s    <= r_ack_meta;
    end
  end

  // Command/response sequencer with registered pad and handshake outputs.
  always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
    if (RST_PAD_I) begin
      r_state     <= ST_INIT;
      r_cnt       <= 8'd0;
      r_tx        <= 48'd0;
      r_dly       <= 3'd0;
      r_rsp_none  <= 1'b0;
      r_rsp_long  <= 1'b0;
      r_crc       <= 7'd0;
      r_rx_crc    <= 7'd0;
      r_dat_ava   <= 1'b0;
      r_crc_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_init_done <= 1'b0;
      r_ack       <= 1'b0;
      r_req       <= 1'b0;
      r_cmd       <= 40'd0;
      r_cmd_out   <= 1'b1;
      r_oe        <= 1'b0;
    end else if (go_idle_i && (r_state != ST_INIT)) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 8'd0;
      r_req       <= 1'b0;
      r_oe        <= 1'b0;
      r_cmd_out   <= 1'b1;
      r_ack       <= 1'b1;
      r_dat_ava   <= 1'b0;
      r_crc_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_cnt == INIT_LAST) begin
            r_oe        <= 1'b0;
            r_init_done <= 1'b1;
            r_ack       <= 1'b1;
            r_cnt       <= 8'd0;
            r_state     <= ST_IDLE;
          end else begin
            r_oe      <= 1'b1;
            r_cmd_out <= 1'b1;
            r_cnt     <= r_cnt + 8'd1;
          end
        end
        ST_IDLE: begin
          r_oe      <= 1'b0;
          r_cmd_out <= 1'b1;
          if (w_req_rise) begin
            r_tx        <= {cmd_i, crc7_40(cmd_i), 1'b1};
            r_dly       <= settings_i[10:8];
            r_rsp_none  <= (settings_i[6:0] == 7'd0);
            r_rsp_long  <= (settings_i[6:0] == 7'd127);
            r_dat_ava   <= 1'b0;
            r_crc_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_ack       <= 1'b0;
            r_cnt       <= 8'd0;
            r_state     <= ST_WRITE;
          end else begin
            r_ack <= 1'b1;
          end
        end
        ST_WRITE: begin
          r_oe      <= 1'b1;
          r_cmd_out <= r_tx[47];
          r_tx      <= {r_tx[46:0], 1'b0};
          if (r_cnt == WRITE_LAST) begin
            r_cnt   <= 8'd0;
            r_state <= ST_DLY;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DLY: begin
          r_oe      <= 1'b0;
          r_cmd_out <= 1'b1;
          if (r_cnt == {5'd0, r_dly}) begin
            r_cnt <= 8'd0;
            if (r_rsp_none) begin
              r_dat_ava   <= 1'b1;
              r_crc_valid <= 1'b1;
              r_req       <= 1'b1;
              r_state     <= ST_REPORT;
            end else begin
              r_state <= ST_WAIT;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_WAIT: begin
          if (!cmd_dat_i) begin
            r_crc   <= crc7_step(7'h00, cmd_dat_i);
            r_cnt   <= 8'd1;
            r_state <= ST_READ;
          end else if (r_cnt == TMO_LAST) begin
            r_timeout <= 1'b1;
            r_dat_ava <= 1'b0;
            r_req     <= 1'b1;
            r_cnt     <= 8'd0;
            r_state   <= ST_REPORT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_READ: begin
          // The start bit was consumed in WAIT; seed cmd_o with it on bit 1.
          if (r_cnt < 8'd40) begin
            r_crc <= crc7_step(r_crc, cmd_dat_i);
            if (r_cnt == 8'd1) begin
              r_cmd <= {38'd0, 1'b0, cmd_dat_i};
            end else begin
              r_cmd <= {r_cmd[38:0], cmd_dat_i};
            end
          end else if (r_cnt < 8'd47) begin
            r_rx_crc <= {r_rx_crc[5:0], cmd_dat_i};
          end else begin
            r_rx_crc <= r_rx_crc;
          end
          if ((r_rsp_long && (r_cnt == LONG_LAST)) || (!r_rsp_long && (r_cnt == SHORT_LAST))) begin
            r_crc_valid <= r_rsp_long | ((r_crc == r_rx_crc) & cmd_dat_i);
            r_dat_ava   <= 1'b1;
            r_req       <= 1'b1;
            r_cnt       <= 8'd0;
            r_state     <= ST_REPORT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_REPORT: begin
          if (r_req) begin
            if (r_ack_s) begin
              r_req <= 1'b0;
            end
          end else if (!r_ack_s) begin
            r_ack   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_oe      <= 1'b0;
          r_cmd_out <= 1'b1;
          r_req     <= 1'b0;
          r_cnt     <= 8'd0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
